// File: rtl/pong_pkg.sv
// Shared constants for the pong controller: FSM encodings, direction
// encodings, default screen/paddle geometry and the serve (centre) position.
package pong_pkg;

   // FSM state encodings, kept as plain vectors so the state port is a
   // simple 2-bit value.
   localparam logic [1:0] QI      = 2'b00;   // idle, waiting for start
   localparam logic [1:0] QGAME_1 = 2'b01;   // serve pause
   localparam logic [1:0] QGAME_2 = 2'b10;   // rally
   localparam logic [1:0] QDONE   = 2'b11;   // game over

   // Direction bits: dx=1 moves right, dy=1 moves down.
   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;
   localparam logic DIR_UP    = 1'b0;
   localparam logic DIR_DOWN  = 1'b1;

   // Default geometry.
   localparam int DEF_SCREEN_W    = 640;
   localparam int DEF_SCREEN_H    = 480;
   localparam int DEF_BALL_SZ     = 8;
   localparam int DEF_STEP        = 2;
   localparam int DEF_P1_X        = 20;
   localparam int DEF_P2_X        = 610;
   localparam int DEF_PAD_W       = 10;
   localparam int DEF_PAD_H       = 50;
   localparam int DEF_WIN_SCORE   = 10;
   localparam int DEF_SERVE_FRAMES = 60;

   // Ball top-left coordinate that centres it on a span.
   function automatic int centre(input int span, input int sz);
      return (span - sz) / 2;
   endfunction

   // Serve position for the default screen: (316,236).
   localparam int CENTRE_X = (DEF_SCREEN_W - DEF_BALL_SZ) / 2;
   localparam int CENTRE_Y = (DEF_SCREEN_H - DEF_BALL_SZ) / 2;

endpackage

// File: rtl/pong_collide.sv
// Combinational collision / scoring decisions for one frame of ball motion.
// Looks only at the current ball position and direction; the caller applies
// the resulting moves.
module pong_collide
   import pong_pkg::*;
#(
   parameter int SCREEN_W = DEF_SCREEN_W,
   parameter int SCREEN_H = DEF_SCREEN_H,
   parameter int BALL_SZ  = DEF_BALL_SZ,
   parameter int STEP     = DEF_STEP,
   parameter int P1_X     = DEF_P1_X,
   parameter int P2_X     = DEF_P2_X,
   parameter int PAD_W    = DEF_PAD_W,
   parameter int PAD_H    = DEF_PAD_H
) (
   input  logic [10:0] ball_x,
   input  logic [9:0]  ball_y,
   input  logic [9:0]  p1_pos,
   input  logic [9:0]  p2_pos,
   input  logic        dx,
   input  logic        dy,
   output logic        reflect_x,
   output logic        reflect_y,
   output logic        point_p1,
   output logic        point_p2
);

   // Paddle contact windows: the ball may arrive anywhere within one STEP of
   // the paddle face, so the window is STEP+1 pixels wide.
   localparam logic [10:0] L_LO   = 11'(P1_X + PAD_W);
   localparam logic [10:0] L_HI   = 11'(P1_X + PAD_W + STEP);
   localparam logic [10:0] R_LO   = 11'(P2_X - BALL_SZ - STEP);
   localparam logic [10:0] R_HI   = 11'(P2_X - BALL_SZ);
   localparam logic [10:0] X_EDGE = 11'(SCREEN_W - BALL_SZ - STEP);
   localparam logic [10:0] STEP_X = 11'(STEP);
   localparam logic [9:0]  Y_EDGE = 10'(SCREEN_H - BALL_SZ - STEP);
   localparam logic [9:0]  STEP_Y = 10'(STEP);

   logic [10:0] by;
   logic        p1_hit;
   logic        p2_hit;
   logic        left_win;
   logic        right_win;

   // Overlap and wall tests, widened to 11 bits so ball_y+BALL_SZ and
   // pos+PAD_H cannot wrap.
   always_comb begin
      by        = {1'b0, ball_y};
      p1_hit    = (by + 11'(BALL_SZ) > {1'b0, p1_pos}) && (by < {1'b0, p1_pos} + 11'(PAD_H));
      p2_hit    = (by + 11'(BALL_SZ) > {1'b0, p2_pos}) && (by < {1'b0, p2_pos} + 11'(PAD_H));
      left_win  = (ball_x >= L_LO) && (ball_x <= L_HI);
      right_win = (ball_x >= R_LO) && (ball_x <= R_HI);
      reflect_x = (dx == DIR_RIGHT) ? (right_win && p2_hit) : (left_win && p1_hit);
      reflect_y = (dy == DIR_DOWN) ? (ball_y >= Y_EDGE) : (ball_y <= STEP_Y);
      point_p2  = (dx == DIR_LEFT)  && !reflect_x && (ball_x < STEP_X);
      point_p1  = (dx == DIR_RIGHT) && !reflect_x && (ball_x >= X_EDGE);
   end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game controller: serve/rally/game-over FSM, ball position and
// direction, scores and winner. All outputs are registers.
module pong_game_ctrl
   import pong_pkg::*;
#(
   parameter int SCREEN_W     = DEF_SCREEN_W,
   parameter int SCREEN_H     = DEF_SCREEN_H,
   parameter int BALL_SZ      = DEF_BALL_SZ,
   parameter int STEP         = DEF_STEP,
   parameter int P1_X         = DEF_P1_X,
   parameter int P2_X         = DEF_P2_X,
   parameter int PAD_W        = DEF_PAD_W,
   parameter int PAD_H        = DEF_PAD_H,
   parameter int WIN_SCORE    = DEF_WIN_SCORE,
   parameter int SERVE_FRAMES = DEF_SERVE_FRAMES
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        frame_tick,
   input  logic [9:0]  p1_pos,
   input  logic [9:0]  p2_pos,
   output logic [10:0] ball_x,
   output logic [9:0]  ball_y,
   output logic [3:0]  p1_score,
   output logic [3:0]  p2_score,
   output logic [1:0]  state,
   output logic        winner
);

   localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

   localparam logic [10:0]      CX         = 11'(centre(SCREEN_W, BALL_SZ));
   localparam logic [9:0]       CY         = 10'(centre(SCREEN_H, BALL_SZ));
   localparam logic [10:0]      STEP_X     = 11'(STEP);
   localparam logic [9:0]       STEP_Y     = 10'(STEP);
   localparam logic [10:0]      P1_BOUNCE  = 11'(P1_X + PAD_W);
   localparam logic [10:0]      P2_BOUNCE  = 11'(P2_X - BALL_SZ);
   localparam logic [9:0]       Y_BOTTOM   = 10'(SCREEN_H - BALL_SZ);
   localparam logic [3:0]       WIN        = 4'(WIN_SCORE);
   localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES);

   logic             dx;
   logic             dy;
   logic [CNT_W-1:0] pause_cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic             reflect_x;
   logic             reflect_y;
   logic             point_p1;
   logic             point_p2;
   logic [10:0]      x_next;
   logic [9:0]       y_next;
   logic [3:0]       p1_inc;
   logic [3:0]       p2_inc;

   pong_collide #(
      .SCREEN_W (SCREEN_W),
      .SCREEN_H (SCREEN_H),
      .BALL_SZ  (BALL_SZ),
      .STEP     (STEP),
      .P1_X     (P1_X),
      .P2_X     (P2_X),
      .PAD_W    (PAD_W),
      .PAD_H    (PAD_H)
   ) u_collide (
      .ball_x    (ball_x),
      .ball_y    (ball_y),
      .p1_pos    (p1_pos),
      .p2_pos    (p2_pos),
      .dx        (dx),
      .dy        (dy),
      .reflect_x (reflect_x),
      .reflect_y (reflect_y),
      .point_p1  (point_p1),
      .point_p2  (point_p2)
   );

   // Candidate ball position for the next frame; a reflection parks the ball
   // against the paddle face or the wall instead of stepping past it.
   always_comb begin
      if (reflect_x) begin
         x_next = (dx == DIR_RIGHT) ? P2_BOUNCE : P1_BOUNCE;
      end else begin
         x_next = (dx == DIR_RIGHT) ? ball_x + STEP_X : ball_x - STEP_X;
      end
      if (reflect_y) begin
         y_next = (dy == DIR_DOWN) ? Y_BOTTOM : 10'd0;
      end else begin
         y_next = (dy == DIR_DOWN) ? ball_y + STEP_Y : ball_y - STEP_Y;
      end
      cnt_inc = pause_cnt + CNT_W'(1);
      p1_inc  = p1_score + 4'd1;
      p2_inc  = p2_score + 4'd1;
   end

   // Game FSM and all game registers; dropping start always returns to idle
   // first, so a tick arriving with a start change never moves the ball.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= QI;
         ball_x    <= CX;
         ball_y    <= CY;
         p1_score  <= 4'd0;
         p2_score  <= 4'd0;
         winner    <= 1'b0;
         dx        <= DIR_LEFT;
         dy        <= DIR_DOWN;
         pause_cnt <= '0;
      end else if (state != QI && !start) begin
         state <= QI;
      end else begin
         case (state)
            QI: begin
               if (start) begin
                  state     <= QGAME_1;
                  p1_score  <= 4'd0;
                  p2_score  <= 4'd0;
                  ball_x    <= CX;
                  ball_y    <= CY;
                  dx        <= DIR_LEFT;
                  dy        <= DIR_DOWN;
                  pause_cnt <= '0;
               end
            end
            QGAME_1: begin
               if (frame_tick) begin
                  if (cnt_inc == SERVE_LAST) begin
                     state     <= QGAME_2;
                     pause_cnt <= '0;
                  end else begin
                     pause_cnt <= cnt_inc;
                  end
               end
            end
            QGAME_2: begin
               if (frame_tick) begin
                  if (point_p1) begin
                     p1_score <= p1_inc;
                     if (p1_inc == WIN) begin
                        state  <= QDONE;
                        winner <= 1'b0;
                     end else begin
                        state     <= QGAME_1;
                        ball_x    <= CX;
                        ball_y    <= CY;
                        dx        <= DIR_RIGHT;
                        pause_cnt <= '0;
                     end
                  end else if (point_p2) begin
                     p2_score <= p2_inc;
                     if (p2_inc == WIN) begin
                        state  <= QDONE;
                        winner <= 1'b1;
                     end else begin
                        state     <= QGAME_1;
                        ball_x    <= CX;
                        ball_y    <= CY;
                        dx        <= DIR_LEFT;
                        pause_cnt <= '0;
                     end
                  end else begin
                     ball_x <= x_next;
                     ball_y <= y_next;
                     if (reflect_x) dx <= ~dx;
                     if (reflect_y) dy <= ~dy;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/pong_game_ctrl.md
PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- SCREEN_W, 640, visible width in px
- SCREEN_H, 480, visible height in px
- BALL_SZ, 8, ball edge in px
- STEP, 2, ball px per frame on each axis
- P1_X, 20, left paddle left edge
- P2_X, 610, right paddle left edge
- PAD_W, 10, paddle width
- PAD_H, 50, paddle height
- WIN_SCORE, 10, winning score
- SERVE_FRAMES, 60, serve pause in frames
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, in, 1, system clock
- reset, in, 1, asynchronous, active-low
- start, in, 1, game enable level (switch)
- frame_tick, in, 1, one-cycle pulse per video frame
- p1_pos, in, 10, left paddle top Y
- p2_pos, in, 10, right paddle top Y
- ball_x, out, 11, ball left X
- ball_y, out, 10, ball top Y
- p1_score, out, 4, player 1 score
- p2_score, out, 4, player 2 score
- state, out, 2, FSM state
- winner, out, 1, 0 = P1 won, 1 = P2 won; valid in QDONE

Function
REQ-003 States: QI=00 idle, QGAME_1=01 serve pause, QGAME_2=10 rally, QDONE=11 game over; all outputs registered.
REQ-004 QI->QGAME_1 when start=1; on this transition scores clear, ball centres to (316,236), dx=left, dy=down, pause counter clears.
REQ-005 start=0 in QGAME_1/QGAME_2/QDONE -> QI next cycle; scores and ball hold.
REQ-006 QGAME_1: pause counter increments per frame_tick; on the tick that brings it to SERVE_FRAMES -> QGAME_2 and the counter clears.
REQ-007 QGAME_2: ball updates only on frame_tick; no change between ticks.
REQ-008 Y axis, moving up: ball_y<=STEP -> ball_y=0, dy flips to down; else ball_y-=STEP.
REQ-009 Y axis, moving down: ball_y>=SCREEN_H-BALL_SZ-STEP -> ball_y=472, dy flips to up; else ball_y+=STEP.
REQ-010 Y overlap with paddle P: ball_y+BALL_SZ > P_pos and ball_y < P_pos+PAD_H, using 11-bit unsigned compares.
REQ-011 Moving left:
- 30<=ball_x<=32 with p1 overlap -> ball_x=30, dx flips to right.
- else ball_x<STEP -> point to P2.
- else ball_x-=STEP.
REQ-012 Moving right:
- 600<=ball_x<=602 with p2 overlap -> ball_x=602, dx flips to left.
- else ball_x>=SCREEN_W-BALL_SZ-STEP -> point to P1.
- else ball_x+=STEP.
REQ-013 X and Y rules evaluate independently on the same tick; a corner hit applies both reflections.
REQ-014 On a point:
- the scorer's score increments by 1.
- if the new score equals WIN_SCORE: ->QDONE, winner set, ball holds.
- otherwise: ->QGAME_1, ball recentres to (316,236), dx points toward the player who conceded, dy unchanged.
REQ-015 Scores never exceed WIN_SCORE; QDONE ignores frame_tick.
REQ-016 frame_tick in the same cycle as a start change: the start transition wins; no motion occurs.

Reset
REQ-017 reset=0 asynchronously forces:
- state=QI
- ball_x=316, ball_y=236
- scores=0, winner=0
- dx=left, dy=down
- pause counter=0
REQ-018 Reset asserted mid-rally aborts the rally with no point awarded; after release the FSM waits in QI for start=1.

Structure
REQ-019 Shared package pong_pkg holds the state encodings (QI..QDONE), screen/paddle constants and the centre coordinates.
REQ-020 Sub-module pong_collide is combinational: it takes the ball, paddle positions and direction bits, and returns reflect_x, reflect_y, point_p1 and point_p2. The FSM and registers live in pong_game_ctrl.

Verification
REQ-021 Start 0->1 from reset -> state 01; after 60 frame_ticks -> state 10, ball at (316,236).
REQ-022 Ball (40,100) moving left, p1_pos=80, 5 ticks -> tick 5 gives ball_x=30, dx=right, ball_y advanced by STEP each tick.
REQ-023 Ball (4,100) moving left, p1_pos=300 -> ticks to x=2, then x=0, then point: p2_score=1, state 01, ball (316,236), dx=left.
REQ-024 Ball (602,1) moving right/up, p2_pos=0 -> single tick: ball (602,0), both dx and dy flip.
REQ-025 p1_score=9, P1 point -> p1_score=10, state 11, winner=0; further ticks leave all outputs unchanged; start=0 -> state 00.
REQ-026 reset=0 pulsed mid-rally, asynchronous to clk -> outputs take reset values before the next clk edge; scores=0.
